// File: rtl/restriction_sweep_harness.sv
// Sweeps the free inputs of a restricted single-output function and
// accumulates an on-set count and MISR signature of its response.
module restriction_sweep_harness #(
    parameter int          N_IN     = 25,
    parameter int          CNT_W    = 26,
    parameter logic [15:0] SIG_SEED = 16'hFFFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [N_IN-1:0]  fix_mask,
    input  logic [N_IN-1:0]  fix_val,
    output logic [N_IN-1:0]  vec_out,
    output logic             vec_vld,
    input  logic             y_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] onset_cnt,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [15:0]      sig
);

    localparam int IW = $clog2(CNT_W);
    localparam int PW = $clog2(N_IN + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_IN-1:0]   r_mask;
    logic [N_IN-1:0]   r_val;
    logic [CNT_W-1:0]  r_total;
    logic [CNT_W-1:0]  r_cnt;
    logic [N_IN-1:0]   r_vec;
    logic              r_vld;
    logic [CNT_W-1:0]  r_onset;
    logic [CNT_W-1:0]  r_vcnt;
    logic [15:0]       r_sig;
    logic [N_IN-1:0]   w_scat;
    logic [PW-1:0]     w_free;
    logic              w_start;
    logic              w_step;
    logic              w_more;

    assign w_start = !abort && !hold && start && (r_state != S_RUN);
    assign w_step  = !abort && !hold && (r_state == S_RUN);
    assign w_more  = r_cnt < r_total;

    // Bit i of the counter lands on the i-th free input, lowest first
    always_comb begin
        logic [IW-1:0] j;
        w_scat = '0;
        j      = '0;
        for (int k = 0; k < N_IN; k++) begin
            if (r_mask[k]) begin
                w_scat[k] = r_val[k];
            end else begin
                w_scat[k] = r_cnt[j];
                j         = j + IW'(1);
            end
        end
    end

    always_comb begin
        w_free = '0;
        for (int k = 0; k < N_IN; k++)
            w_free = w_free + PW'(!fix_mask[k]);
    end

    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = S_IDLE;
        end else if (!hold) begin
            case (r_state)
                S_IDLE:  if (start) w_next = S_RUN;
                S_DONE:  if (start) w_next = S_RUN;
                S_RUN:   if (!w_more) w_next = S_DONE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_val   <= '0;
            r_total <= '0;
            r_cnt   <= '0;
            r_vec   <= '0;
            r_vld   <= 1'b0;
            r_onset <= '0;
            r_vcnt  <= '0;
            r_sig   <= SIG_SEED;
        end else if (abort) begin
            r_vld <= 1'b0;
        end else if (w_start) begin
            r_mask  <= fix_mask;
            r_val   <= fix_val;
            r_total <= CNT_W'(1) << w_free;
            r_cnt   <= '0;
            r_onset <= '0;
            r_vcnt  <= '0;
            r_sig   <= SIG_SEED;
        end else if (w_step) begin
            if (r_vld) begin
                r_onset <= r_onset + CNT_W'(y_in);
                r_vcnt  <= r_vcnt + CNT_W'(1);
                r_sig   <= {r_sig[14:0],
                            r_sig[15] ^ r_sig[13] ^ r_sig[12] ^ r_sig[10] ^ y_in};
            end
            if (w_more) begin
                r_vec <= w_scat;
                r_vld <= 1'b1;
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_vld <= 1'b0;
            end
        end
    end

    assign vec_out   = r_vec;
    assign vec_vld   = r_vld;
    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign onset_cnt = r_onset;
    assign vec_cnt   = r_vcnt;
    assign sig       = r_sig;

endmodule

// File: tb/tb_restriction_sweep_harness.sv
// Directed and randomized sweeps of restriction_sweep_harness against a
// free-position-list reference model and a cube-list golden PLA.
module tb_restriction_sweep_harness;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        hold = 1'b0;
    logic [24:0] fix_mask = '0;
    logic [24:0] fix_val = '0;
    logic [24:0] vec_out;
    logic        vec_vld;
    logic        y_in;
    logic        busy;
    logic        done;
    logic [25:0] onset_cnt;
    logic [25:0] vec_cnt;
    logic [15:0] sig;

    bit          use_net = 1'b0;
    logic        net_y;
    int          errors = 0;
    int          checks = 0;
    logic [24:0] expq[$];

    always #5 clk = ~clk;

    restriction_sweep_harness dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .hold(hold), .fix_mask(fix_mask), .fix_val(fix_val),
        .vec_out(vec_out), .vec_vld(vec_vld), .y_in(y_in),
        .busy(busy), .done(done), .onset_cnt(onset_cnt),
        .vec_cnt(vec_cnt), .sig(sig)
    );

    // Gate-level stand-in for a restricted benchmark netlist
    assign net_y = (vec_out[0] & vec_out[1] & ~vec_out[2])
                 | ((vec_out[3] ^ vec_out[4]) & vec_out[5])
                 | (vec_out[10] & vec_out[11] & vec_out[12])
                 | (vec_out[6] & vec_out[22])
                 | (~vec_out[21] & vec_out[23] & vec_out[24]);
    assign y_in = use_net ? net_y : vec_out[0];

    localparam logic [24:0] CARE [6] = '{25'h7, 25'h38, 25'h38,
        25'h1C00, 25'h400040, 25'h1A00000};
    localparam logic [24:0] CVAL [6] = '{25'h3, 25'h28, 25'h30,
        25'h1C00, 25'h400040, 25'h1800000};

    function automatic logic pla(input logic [24:0] x);
        for (int i = 0; i < 6; i++)
            if ((x & CARE[i]) == CVAL[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic y_model(input logic [24:0] x);
        return use_net ? pla(x) : x[0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build(input logic [24:0] m, input logic [24:0] v,
                         output logic [25:0] on, output logic [15:0] s);
        int          fp[$];
        logic [24:0] x;
        logic        y;
        expq.delete();
        for (int k = 0; k < 25; k++) if (!m[k]) fp.push_back(k);
        on = '0;
        s  = 16'hFFFF;
        for (int c = 0; c < (1 << fp.size()); c++) begin
            x = v & m;
            foreach (fp[i]) if (((c >> i) & 1) != 0) x[fp[i]] = 1'b1;
            expq.push_back(x);
            y  = y_model(x);
            on = on + 26'(y);
            s  = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10] ^ y};
        end
    endtask

    task automatic sweep(input string tag, input logic [24:0] m,
                         input logic [24:0] v, input bit rh);
        logic [25:0] on_exp;
        logic [15:0] sig_exp;
        logic [24:0] prev;
        bit          h;
        int          k = 0;
        int          cyc = 0;
        int          bad = 0;
        int          g = 0;
        build(m, v, on_exp, sig_exp);
        @(negedge clk);
        fix_mask = m;
        fix_val  = v;
        start    = 1'b1;
        hold     = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!done && g < 20000) begin
            h    = rh ? 1'($urandom_range(0, 1)) : 1'b0;
            hold = h;
            if (busy && !h) cyc++;
            if (vec_vld && !h) begin
                if (k >= expq.size() || vec_out !== expq[k]) bad++;
                k++;
            end
            prev = vec_out;
            @(negedge clk);
            if (h && vec_out !== prev) bad++;
            g++;
        end
        hold = 1'b0;
        chk({tag, " done"}, 64'(done), 64'd1);
        chk({tag, " seq"}, 64'(bad), 64'd0);
        if (!rh) chk({tag, " runcyc"}, 64'(cyc), 64'(expq.size() + 1));
        chk({tag, " nvec"}, 64'(k), 64'(expq.size()));
        chk({tag, " vec_cnt"}, 64'(vec_cnt), 64'(expq.size()));
        chk({tag, " onset"}, 64'(onset_cnt), 64'(on_exp));
        chk({tag, " sig"}, 64'(sig), 64'(sig_exp));
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " vld"}, 64'(vec_vld), 64'd0);
        chk({tag, " last"}, 64'(vec_out), 64'(expq[expq.size()-1]));
    endtask

    initial begin
        logic [25:0] u_cnt, u_on;
        logic [15:0] u_sig;
        logic [24:0] m3;
        int          g;

        #12;
        chk("rst vec_out", 64'(vec_out), 64'd0);
        chk("rst vld", 64'(vec_vld), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst cnt", 64'(vec_cnt), 64'd0);
        chk("rst onset", 64'(onset_cnt), 64'd0);
        chk("rst sig", 64'(sig), 64'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        sweep("single", '1, 25'h1, 1'b0);
        chk("single onset1", 64'(onset_cnt), 64'd1);
        sweep("free3", ~25'h7, 25'h0, 1'b0);
        chk("free3 onset4", 64'(onset_cnt), 64'd4);
        sweep("free3r", ~25'h7, 25'($urandom), 1'b0);

        m3 = ~((25'h1 << 3) | (25'h1 << 10) | (25'h1 << 24));
        sweep("scatter", m3, 25'h1, 1'b0);
        chk("scatter v1", 64'(expq[1]), 64'h9);
        chk("scatter onset8", 64'(onset_cnt), 64'd8);
        u_cnt = vec_cnt;
        u_on  = onset_cnt;
        u_sig = sig;
        sweep("held", m3, 25'h1, 1'b1);
        chk("held cnt", 64'(vec_cnt), 64'(u_cnt));
        chk("held onset", 64'(onset_cnt), 64'(u_on));
        chk("held sig", 64'(sig), 64'(u_sig));

        @(negedge clk);
        fix_mask = ~25'h7;
        fix_val  = '0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        g = 0;
        while (vec_cnt != 26'd1 && g < 50) begin @(negedge clk); g++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("run start ign", 64'(vec_cnt), 64'd2);
        chk("run busy", 64'(busy), 64'd1);
        g = 0;
        while (vec_cnt != 26'd3 && g < 50) begin @(negedge clk); g++; end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort vld", 64'(vec_vld), 64'd0);
        chk("abort cnt", 64'(vec_cnt), 64'd3);

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst vec_out", 64'(vec_out), 64'd0);
        chk("arst vld", 64'(vec_vld), 64'd0);
        chk("arst busy", 64'(busy), 64'd0);
        chk("arst cnt", 64'(vec_cnt), 64'd0);
        chk("arst onset", 64'(onset_cnt), 64'd0);
        chk("arst sig", 64'(sig), 64'hFFFF);
        @(negedge clk);
        rst_n = 1'b1;

        use_net = 1'b1;
        sweep("pla", ~(25'h3C0 | 25'h800000 | 25'h1FE000),
              25'($urandom) & 25'h1FE000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
